// File: rtl/ro_puf_multibit_core_pkg.sv
// Shared types and helpers for the multi-bit ring-oscillator PUF core.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COUNT,
    ST_COMPARE,
    ST_DONE
  } state_e;

  // Increment-by-pulse that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                          input logic [31:0] max_val,
                                          input logic inc);
    if (inc && (cnt < max_val)) return cnt + 32'd1;
    return cnt;
  endfunction

endpackage

// File: rtl/ro_puf_multibit_core_edge_sync.sv
// Two-flop synchroniser for one free-running oscillator plus rising-edge pulse in the clk domain.
module ro_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ro_in,
  output logic edge_pulse
);

  logic sync1_q, sync2_q, prev_q;
  logic sync1_d, sync2_d, prev_d;

  always_comb begin
    sync1_d = ro_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign edge_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/ro_puf_multibit_core.sv
// RO PUF evaluation core: counts edges of challenge-selected oscillator pairs over a fixed window
// and assembles a multi-bit response with tie count and minimum reliability margin.
module ro_puf_multibit_core
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO    = 16,
  parameter int RESP_BITS = 8,
  parameter int WIN_LOG2  = 8,
  parameter int CNT_W     = 10,
  localparam int CH_W     = $clog2(NUM_RO),
  localparam int TIE_W    = $clog2(RESP_BITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [CH_W-1:0]   challenge,
  input  logic [NUM_RO-1:0] ro_in,
  output logic              busy,
  output logic              done,
  output logic              resp_valid,
  output logic [RESP_BITS-1:0] response,
  output logic [TIE_W-1:0]  tie_cnt,
  output logic [CNT_W-1:0]  min_margin
);

  localparam int KW = $clog2(RESP_BITS + 1);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  function automatic logic [CH_W-1:0] wrap_idx(input int unsigned v);
    return CH_W'(v % NUM_RO);
  endfunction

  logic [NUM_RO-1:0] edge_pulse;

  for (genvar i = 0; i < NUM_RO; i++) begin : g_sync
    ro_edge_sync u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .ro_in      (ro_in[i]),
      .edge_pulse (edge_pulse[i])
    );
  end

  state_e                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [WIN_LOG2-1:0]    win_q, win_d;
  logic [CNT_W-1:0]       cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic                   busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic [RESP_BITS-1:0]   resp_q, resp_d;
  logic [TIE_W-1:0]       tie_q, tie_d;
  logic [CNT_W-1:0]       margin_q, margin_d;

  logic [CH_W-1:0]        a_sel, b_sel;
  logic                   a_gt_b;
  logic [CNT_W-1:0]       diff;

  always_comb begin
    a_sel  = wrap_idx(32'(ch_q) + 32'(k_q) * 32'd2);
    b_sel  = wrap_idx(32'(a_sel) + 32'd1);
    a_gt_b = cnt_a_q > cnt_b_q;
    diff   = a_gt_b ? (cnt_a_q - cnt_b_q) : (cnt_b_q - cnt_a_q);
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    ch_d     = ch_q;
    win_d    = win_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    resp_d   = resp_q;
    tie_d    = tie_q;
    margin_d = margin_q;
    // Dropping ena anywhere in an evaluation throws away the partial result.
    if ((state_q != ST_IDLE) && !ena) begin
      state_d  = ST_IDLE;
      busy_d   = 1'b0;
      valid_d  = 1'b0;
      resp_d   = '0;
      tie_d    = '0;
      margin_d = '1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ena && start && !done_q) begin
            ch_d     = challenge;
            k_d      = '0;
            busy_d   = 1'b1;
            valid_d  = 1'b0;
            resp_d   = '0;
            tie_d    = '0;
            margin_d = '1;
            state_d  = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          cnt_a_d = '0;
          cnt_b_d = '0;
          win_d   = '0;
          state_d = ST_COUNT;
        end
        ST_COUNT: begin
          cnt_a_d = CNT_W'(sat_inc(32'(cnt_a_q), CNT_MAX, edge_pulse[a_sel]));
          cnt_b_d = CNT_W'(sat_inc(32'(cnt_b_q), CNT_MAX, edge_pulse[b_sel]));
          win_d   = win_q + 1'b1;
          if (win_q == '1) state_d = ST_COMPARE;
        end
        ST_COMPARE: begin
          for (int i = 0; i < RESP_BITS; i++) begin
            if (KW'(i) == k_q) resp_d[i] = a_gt_b;
          end
          if (cnt_a_q == cnt_b_q) tie_d = tie_q + TIE_W'(1);
          if (diff < margin_q) margin_d = diff;
          if (k_q == KW'(RESP_BITS - 1)) begin
            state_d = ST_DONE;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = ST_CLEAR;
          end
        end
        ST_DONE: begin
          done_d  = 1'b1;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      ch_q     <= '0;
      win_q    <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      resp_q   <= '0;
      tie_q    <= '0;
      margin_q <= '1;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      ch_q     <= ch_d;
      win_q    <= win_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      resp_q   <= resp_d;
      tie_q    <= tie_d;
      margin_q <= margin_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign resp_valid = valid_q;
  assign response   = resp_q;
  assign tie_cnt    = tie_q;
  assign min_margin = margin_q;

endmodule
